// File: rtl/ddr3_dfi_init_seq.sv
// DDR3 power-up/initialisation sequencer driving the DFI command bus; every output is registered.
// Optional ZQ calibration step (ZQCL + tZQinit wait) is compiled only when DDR3_INIT_ZQCL_EN is defined.
module ddr3_dfi_init_seq #(
  parameter int                    ADDR_WIDTH   = 14,
  parameter int                    RESET_CYCLES = 20000,
  parameter int                    CKE_CYCLES   = 50000,
  parameter int                    TXPR         = 28,
  parameter int                    TMRD         = 4,
  parameter int                    TMOD         = 12,
  parameter int                    TZQINIT      = 512,
  parameter logic [ADDR_WIDTH-1:0] MR0          = 14'h0520,
  parameter logic [ADDR_WIDTH-1:0] MR1          = 14'h0044,
  parameter logic [ADDR_WIDTH-1:0] MR2          = 14'h0008,
  parameter logic [ADDR_WIDTH-1:0] MR3          = 14'h0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dfi_init_complete,
  output logic                  dfi_reset_n,
  output logic                  dfi_cke,
  output logic                  dfi_cs_n,
  output logic                  dfi_ras_n,
  output logic                  dfi_cas_n,
  output logic                  dfi_we_n,
  output logic                  dfi_odt,
  output logic [2:0]            dfi_bank,
  output logic [ADDR_WIDTH-1:0] dfi_address,
  output logic                  init_done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(max2(max2(RESET_CYCLES, CKE_CYCLES), max2(TXPR, TMRD)),
                             max2(TMOD, TZQINIT));
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam logic [ADDR_WIDTH-1:0] ZQ_ADDR = {{(ADDR_WIDTH-11){1'b0}}, 1'b1, 10'b0};

  typedef enum logic [3:0] {
    IDLE,
    RST_HOLD,
    CKE_WAIT,
    XPR,
    MRS2,
    MRS3,
    MRS1,
    MRS0,
    MOD,
`ifdef DDR3_INIT_ZQCL_EN
    ZQCL,
    ZQ_WAIT,
`endif
    DONE
  } state_t;

  // Reload value so that a state of length len lasts max(len,1) clocks.
  function automatic logic [CW-1:0] ld(input int len);
    return (len <= 1) ? '0 : CW'(len - 1);
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  reset_n_q, reset_n_d;
  logic                  cke_q, cke_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [2:0]            bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  done_q, done_d;
  logic                  entering;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (dfi_init_complete) state_d = RST_HOLD;
    end else if (state_q != DONE && cnt_q == '0) begin
      case (state_q)
        RST_HOLD: state_d = CKE_WAIT;
        CKE_WAIT: state_d = XPR;
        XPR:      state_d = MRS2;
        MRS2:     state_d = MRS3;
        MRS3:     state_d = MRS1;
        MRS1:     state_d = MRS0;
        MRS0:     state_d = MOD;
`ifdef DDR3_INIT_ZQCL_EN
        MOD:      state_d = ZQCL;
        ZQCL:     state_d = ZQ_WAIT;
        ZQ_WAIT:  state_d = DONE;
`else
        MOD:      state_d = DONE;
`endif
        default:  state_d = DONE;
      endcase
    end
  end

  assign entering = (state_d != state_q);

  // MR0 is a single command cycle; MOD covers the rest of tMOD so MR0-to-next spacing is TMOD.
  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    if (entering) begin
      case (state_d)
        RST_HOLD: cnt_d = ld(RESET_CYCLES);
        CKE_WAIT: cnt_d = ld(CKE_CYCLES);
        XPR:      cnt_d = ld(TXPR);
        MRS2,
        MRS3,
        MRS1:     cnt_d = ld(TMRD);
        MOD:      cnt_d = ld(TMOD - 1);
`ifdef DDR3_INIT_ZQCL_EN
        ZQ_WAIT:  cnt_d = ld(TZQINIT - 1);
`endif
        default:  cnt_d = '0;
      endcase
    end
  end

  // Outputs are computed for the upcoming state and registered, so they line up with state_q.
  always_comb begin
    reset_n_d = 1'b1;
    cke_d     = 1'b1;
    cmd_d     = CMD_NOP;
    bank_d    = 3'd0;
    addr_d    = '0;
    done_d    = 1'b0;
    case (state_d)
      IDLE, RST_HOLD: begin
        reset_n_d = 1'b0;
        cke_d     = 1'b0;
        cmd_d     = CMD_DESEL;
      end
      CKE_WAIT: begin
        cke_d = 1'b0;
        cmd_d = CMD_DESEL;
      end
      MRS2: if (entering) begin cmd_d = CMD_MRS; bank_d = 3'd2; addr_d = MR2; end
      MRS3: if (entering) begin cmd_d = CMD_MRS; bank_d = 3'd3; addr_d = MR3; end
      MRS1: if (entering) begin cmd_d = CMD_MRS; bank_d = 3'd1; addr_d = MR1; end
      MRS0: if (entering) begin cmd_d = CMD_MRS; bank_d = 3'd0; addr_d = MR0; end
`ifdef DDR3_INIT_ZQCL_EN
      ZQCL: if (entering) begin cmd_d = CMD_ZQCL; addr_d = ZQ_ADDR; end
`endif
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      cmd_q     <= CMD_DESEL;
      bank_q    <= 3'd0;
      addr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reset_n_q <= reset_n_d;
      cke_q     <= cke_d;
      cmd_q     <= cmd_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

  assign dfi_reset_n = reset_n_q;
  assign dfi_cke     = cke_q;
  assign dfi_cs_n    = cmd_q[3];
  assign dfi_ras_n   = cmd_q[2];
  assign dfi_cas_n   = cmd_q[1];
  assign dfi_we_n    = cmd_q[0];
  assign dfi_odt     = 1'b0;
  assign dfi_bank    = bank_q;
  assign dfi_address = addr_q;
  assign init_done   = done_q;

endmodule

// File: tb/tb_ddr3_dfi_init_seq.sv
// Directed bench for ddr3_dfi_init_seq: per-cycle comparison of the full DFI output vector
// against a hand-derived timeline (RESET=10, CKE=20, TXPR=5, TMRD=4, TMOD=12, TZQINIT=16).
module tb_ddr3_dfi_init_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        dfi_init_complete;
  logic        dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt;
  logic [2:0]  dfi_bank;
  logic [13:0] dfi_address;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  ddr3_dfi_init_seq #(
    .ADDR_WIDTH  (14),
    .RESET_CYCLES(10),
    .CKE_CYCLES  (20),
    .TXPR        (5),
    .TMRD        (4),
    .TMOD        (12),
    .TZQINIT     (16),
    .MR0         (14'h0520),
    .MR1         (14'h0044),
    .MR2         (14'h0008),
    .MR3         (14'h0000)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dfi_init_complete(dfi_init_complete),
    .dfi_reset_n      (dfi_reset_n),
    .dfi_cke          (dfi_cke),
    .dfi_cs_n         (dfi_cs_n),
    .dfi_ras_n        (dfi_ras_n),
    .dfi_cas_n        (dfi_cas_n),
    .dfi_we_n         (dfi_we_n),
    .dfi_odt          (dfi_odt),
    .dfi_bank         (dfi_bank),
    .dfi_address      (dfi_address),
    .init_done        (init_done)
  );

  always #5 clock = ~clock;

  // {reset_n, cke, cs_n, ras_n, cas_n, we_n, odt, bank[2:0], address[13:0], init_done}
  localparam logic [24:0] RST_VEC = {1'b0, 1'b0, 4'b1111, 1'b0, 3'd0, 14'h0000, 1'b0};

  function automatic logic [24:0] obs_vec();
    return {dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt,
            dfi_bank, dfi_address, init_done};
  endfunction

  // Expected outputs k clocks after dfi_init_complete is first sampled high.
  function automatic logic [24:0] exp_vec(input int k);
    logic       rn = 1'b1, ck = 1'b1, dn = 1'b0;
    logic [3:0] cmd = 4'b0111;
    logic [2:0] ba = 3'd0;
    logic [13:0] ad = 14'h0000;
    if (k <= 10) begin rn = 1'b0; ck = 1'b0; cmd = 4'b1111; end
    else if (k <= 30) begin ck = 1'b0; cmd = 4'b1111; end
    else if (k == 36) begin cmd = 4'b0000; ba = 3'd2; ad = 14'h0008; end
    else if (k == 40) begin cmd = 4'b0000; ba = 3'd3; ad = 14'h0000; end
    else if (k == 44) begin cmd = 4'b0000; ba = 3'd1; ad = 14'h0044; end
    else if (k == 48) begin cmd = 4'b0000; ba = 3'd0; ad = 14'h0520; end
`ifdef DDR3_INIT_ZQCL_EN
    else if (k == 60) begin cmd = 4'b0110; ad = 14'h0400; end
    if (k >= 76) dn = 1'b1;
`else
    if (k >= 60) dn = 1'b1;
`endif
    return {rn, ck, cmd, 1'b0, ba, ad, dn};
  endfunction

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts the sequence and checks every cycle up to ncyc; drops init_complete after cycle drop_at.
  task automatic run_seq(input string name, input int ncyc, input int drop_at);
    @(negedge clock);
    dfi_init_complete = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      check($sformatf("%s_cyc%0d", name, k), obs_vec(), exp_vec(k));
      if (k == drop_at) dfi_init_complete = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    dfi_init_complete = 1'b0;
    #12;
    check("reset_asserted", obs_vec(), RST_VEC);
    @(negedge clock);
    reset = 1'b0;

    // Idle with no PHY ready: must not leave reset values.
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (i % 10 == 0) check($sformatf("idle_%0d", i), obs_vec(), RST_VEC);
    end

    // Full sequence with init_complete dropped mid CKE_WAIT.
    run_seq("seq1", 85, 15);

    // Reset from DONE: immediate return to reset values.
    #2 reset = 1'b1;
    #1 check("reset_from_done", obs_vec(), RST_VEC);
    @(negedge clock);
    reset = 1'b0;
    dfi_init_complete = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_after_done_reset", obs_vec(), RST_VEC);

    // Run into MRS1 (entered at cycle 44), then pulse reset asynchronously.
    run_seq("seq2", 45, 1);
    #2 reset = 1'b1;
    #1 check("reset_in_mrs1", obs_vec(), RST_VEC);
    @(negedge clock);
    check("reset_held_mrs1", obs_vec(), RST_VEC);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_after_mrs1_reset", obs_vec(), RST_VEC);

    // Full restart from IDLE.
    run_seq("seq3", 85, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr3_dfi_init_seq.md
DDR3_DFI_INIT_SEQ -- requirements
Module: ddr3_dfi_init_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, DFI row/column address width.
REQ-002 SHALL have parameter RESET_CYCLES, default 20000, dfi_reset_n low-hold time in clocks.
REQ-003 SHALL have parameter CKE_CYCLES, default 50000, reset_n-high-to-CKE-high time in clocks.
REQ-004 SHALL have parameters TXPR, TMRD, TMOD, TZQINIT, defaults 28, 4, 12, 512, in clocks.
REQ-005 SHALL have parameters MR0..MR3, each ADDR_WIDTH bits, defaults 14'h0520, 14'h0044, 14'h0008, 14'h0000.
REQ-006 SHALL have port clock, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port dfi_init_complete, input, 1, PHY ready.
REQ-009 SHALL have ports dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, each output, 1.
REQ-010 SHALL have ports dfi_bank (output, 3) and dfi_address (output, ADDR_WIDTH).
REQ-011 SHALL have port init_done, output, 1, DDR3 initialisation finished.

Function
REQ-012 SHALL drive every output from a register; no combinational input-to-output path.
REQ-013 SHALL implement states IDLE, RST_HOLD, CKE_WAIT, XPR, MRS2, MRS3, MRS1, MRS0, MOD, ZQCL, ZQ_WAIT, DONE.
REQ-014 SHALL stay in IDLE (outputs at reset values) until dfi_init_complete is sampled high, then enter RST_HOLD.
REQ-015 SHALL hold dfi_reset_n=0, dfi_cke=0 for exactly RESET_CYCLES clocks in RST_HOLD.
REQ-016 SHALL drive dfi_reset_n=1, dfi_cke=0 for exactly CKE_CYCLES clocks in CKE_WAIT.
REQ-017 SHALL raise dfi_cke=1 on entry to XPR and keep it high thereafter until reset.
REQ-018 SHALL issue NOP (cs_n=0, ras_n=cas_n=we_n=1) every cycle while dfi_cke=1 and no command is issued.
REQ-019 SHALL remain in XPR for exactly TXPR clocks before the first MRS.
REQ-020 SHALL issue MRS (cs_n=ras_n=cas_n=we_n=0) for one clock per state, order MR2, MR3, MR1, MR0, with dfi_bank = MR index and dfi_address = MRn.
REQ-021 SHALL space consecutive MRS commands exactly TMRD clocks apart (command cycle plus TMRD-1 NOPs).
REQ-022 SHALL wait TMOD clocks from MR0 command to the next command (MOD state).
REQ-023 SHALL, in ZQCL, issue one-cycle ZQCL (cs_n=0, ras_n=1, cas_n=1, we_n=0, address bit 10=1, others 0, bank 0).
REQ-024 SHALL wait TZQINIT clocks after ZQCL (ZQ_WAIT), then enter DONE.
REQ-025 SHALL assert init_done=1 in DONE, issue NOPs, and remain in DONE until reset.
REQ-026 SHALL hold dfi_odt=0 in all states.
REQ-027 SHALL ignore dfi_init_complete once IDLE is left; a deassertion mid-sequence does not abort or restart.
REQ-028 SHALL size the shared delay counter to hold the largest cycle parameter without wrap; counter reloads on every state change.
REQ-029 SHALL treat any timing parameter value of 0 or 1 as a one-clock state.

Reset
REQ-030 SHALL on reset assertion immediately force IDLE, counter 0, dfi_reset_n=0, dfi_cke=0, dfi_cs_n=1, dfi_ras_n=dfi_cas_n=dfi_we_n=1, dfi_odt=0, dfi_bank=0, dfi_address=0, init_done=0.
REQ-031 SHALL restart the full sequence from IDLE after reset mid-operation, including from DONE.

Configuration
REQ-032 SHALL compile ZQCL and ZQ_WAIT only when macro DDR3_INIT_ZQCL_EN is defined.
REQ-033 SHALL, without DDR3_INIT_ZQCL_EN, transition MOD directly to DONE after TMOD clocks, never issuing ZQCL.

Verification
REQ-034 SHALL cover: reset high then low, dfi_init_complete=0 for 50 clocks -> outputs stay at reset values, init_done=0.
REQ-035 SHALL cover: RESET_CYCLES=10, CKE_CYCLES=20, TXPR=5 -> dfi_reset_n low 10 clocks, cke low further 20, first MRS exactly 5 clocks after cke rises.
REQ-036 SHALL cover: TMRD=4, MR2=14'h0008 -> MRS commands 4 clocks apart, bank sequence 2,3,1,0, first address 14'h0008.
REQ-037 SHALL cover: DDR3_INIT_ZQCL_EN defined, TMOD=12, TZQINIT=16 -> ZQCL with address 14'h0400 12 clocks after MR0, init_done 16 clocks later; undefined -> init_done 12 clocks after MR0, no ZQCL.
REQ-038 SHALL cover: reset pulsed during MRS1 -> outputs return to reset values same cycle, sequence restarts from IDLE.
REQ-039 SHALL cover: dfi_init_complete dropped during CKE_WAIT -> sequence timing unchanged, init_done still asserted.
